// File: rtl/ahb_output_arbiter_param.sv
// ahb_output_arbiter_param: output-stage arbiter with port masking, fixed/round-robin priority and burst hold
module ahb_output_arbiter_param #(
    parameter int                   NUM_PORTS  = 5,
    parameter int                   PORT_W     = 3,
    parameter logic [NUM_PORTS-1:0] PORT_MASK  = 5'b11011,
    parameter int                   ARB_MODE   = 0,
    parameter int                   BURST_HOLD = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic [NUM_PORTS-1:0] eff_req, above_ptr, rr_req;
    logic [PORT_W-1:0]    rr_ptr, fix_win, rr_win, win, nxt_port, nxt_ptr;
    logic [3:0]           beat_cnt, nxt_cnt, burst_len;
    logic                 nxt_none, hold;

    function automatic logic [PORT_W-1:0] lowest(input logic [NUM_PORTS-1:0] v);
        lowest = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (v[i]) lowest = PORT_W'(i);
    endfunction

    // the current owner keeps requesting while it has an active transfer on this slave
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
        assign eff_req[i]   = PORT_MASK[i] & (req_port[i] | ((addr_in_port == PORT_W'(i)) & HSELM & (HTRANSM != IDLE)));
        assign above_ptr[i] = PORT_W'(i) > rr_ptr;
    end

    // round-robin: lowest requester above the pointer, else wrap to the lowest overall
    assign rr_req     = eff_req & above_ptr;
    assign fix_win    = lowest(eff_req);
    assign rr_win     = |rr_req ? lowest(rr_req) : fix_win;
    assign win        = (ARB_MODE != 0) ? rr_win : fix_win;
    assign hold       = (BURST_HOLD != 0) && (beat_cnt != 4'd0);
    assign burst_hold = hold;
    assign burst_len  = HBURSTM[2:1] == 2'b01 ? 4'd3 :
                        HBURSTM[2:1] == 2'b10 ? 4'd7 :
                        HBURSTM[2:1] == 2'b11 ? 4'd15 : 4'd0;
    assign nxt_cnt    = HTRANSM == IDLE                       ? 4'd0 :
                        (HTRANSM == NONSEQ && HSELM)          ? burst_len :
                        (HTRANSM == SEQ && beat_cnt != 4'd0)  ? beat_cnt - 4'd1 : beat_cnt;

    always_comb begin
        nxt_port = addr_in_port;
        nxt_none = no_port;
        nxt_ptr  = rr_ptr;
        if (!HMASTLOCKM) begin
            if (hold) begin
                nxt_none = 1'b0;
            end else if (|eff_req) begin
                nxt_port = win;
                nxt_none = 1'b0;
                nxt_ptr  = (ARB_MODE != 0) ? win : rr_ptr;
            end else if (!HSELM) begin
                nxt_none = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            rr_ptr       <= PORT_W'(NUM_PORTS - 1);
            beat_cnt     <= 4'd0;
        end else if (HREADYM) begin
            addr_in_port <= nxt_port;
            no_port      <= nxt_none;
            rr_ptr       <= nxt_ptr;
            beat_cnt     <= nxt_cnt;
        end
    end
endmodule

// File: tb/tb_ahb_output_arbiter_param.sv
// tb_ahb_output_arbiter_param: three arbiter configurations checked every cycle against a behavioural model
module tb_ahb_output_arbiter_param;
    logic       HCLK = 1'b0, HRESETn = 1'b0;
    logic [4:0] req_port = '0;
    logic       HREADYM = 1'b1, HSELM = 1'b0, HMASTLOCKM = 1'b0;
    logic [1:0] HTRANSM = 2'b00;
    logic [2:0] HBURSTM = 3'b000;
    logic [2:0] port_o [3];
    logic       none_o [3];
    logic       hold_o [3];
    int         errors = 0, checks = 0;
    int         m_port [3];
    bit         m_none [3];
    int         m_ptr  [3];
    int         m_beats;

    always #5 HCLK = ~HCLK;

    // instance 0: fixed, mask 11011; instance 1: fixed, mask 11001; instance 2: round-robin, mask 11011
    ahb_output_arbiter_param #(.NUM_PORTS(5), .PORT_W(3), .PORT_MASK(5'b11011), .ARB_MODE(0), .BURST_HOLD(1)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM),
        .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .addr_in_port(port_o[0]), .no_port(none_o[0]), .burst_hold(hold_o[0]));
    ahb_output_arbiter_param #(.NUM_PORTS(5), .PORT_W(3), .PORT_MASK(5'b11001), .ARB_MODE(0), .BURST_HOLD(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM),
        .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .addr_in_port(port_o[1]), .no_port(none_o[1]), .burst_hold(hold_o[1]));
    ahb_output_arbiter_param #(.NUM_PORTS(5), .PORT_W(3), .PORT_MASK(5'b11011), .ARB_MODE(1), .BURST_HOLD(1)) dut2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM),
        .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM), .addr_in_port(port_o[2]), .no_port(none_o[2]), .burst_hold(hold_o[2]));

    function automatic logic [4:0] mask_of(input int j);
        return (j == 1) ? 5'b11001 : 5'b11011;
    endfunction

    function automatic int beats_of(input logic [2:0] b);
        if (b == 3'd2 || b == 3'd3) return 4;
        if (b == 3'd4 || b == 3'd5) return 8;
        if (b == 3'd6 || b == 3'd7) return 16;
        return 1;
    endfunction

    task automatic model_next(input int j, output int np, output bit nn, output int nptr);
        logic [4:0] m;
        logic [4:0] eff;
        int w;
        m = mask_of(j);
        np = m_port[j]; nn = m_none[j]; nptr = m_ptr[j];
        for (int i = 0; i < 5; i++)
            eff[i] = m[i] && (req_port[i] || (m_port[j] == i && HSELM && HTRANSM != 2'b00));
        if (HMASTLOCKM) begin
        end else if (m_beats != 0) begin
            nn = 1'b0;
        end else if (eff != 5'b0) begin
            w = -1;
            if (j != 2) begin
                for (int i = 4; i >= 0; i--)
                    if (eff[i]) w = i;
            end else begin
                for (int k = 1; k <= 5; k++)
                    if (w < 0 && eff[(m_ptr[j] + k) % 5]) w = (m_ptr[j] + k) % 5;
                nptr = w;
            end
            np = w; nn = 1'b0;
        end else if (!HSELM) begin
            nn = 1'b1;
        end
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int j = 0; j < 3; j++) begin
                m_port[j] <= 0; m_none[j] <= 1'b1; m_ptr[j] <= 4;
            end
            m_beats <= 0;
        end else if (HREADYM) begin
            for (int j = 0; j < 3; j++) begin
                int np, nptr;
                bit nn;
                model_next(j, np, nn, nptr);
                m_port[j] <= np; m_none[j] <= nn; m_ptr[j] <= nptr;
            end
            if (HTRANSM == 2'b00) m_beats <= 0;
            else if (HTRANSM == 2'b10 && HSELM) m_beats <= beats_of(HBURSTM) - 1;
            else if (HTRANSM == 2'b11 && m_beats > 0) m_beats <= m_beats - 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("model%0d_port", j), int'(port_o[j]), m_port[j]);
            chk($sformatf("model%0d_none", j), int'(none_o[j]), int'(m_none[j]));
            chk($sformatf("model%0d_hold", j), int'(hold_o[j]), int'(m_beats != 0));
        end
    end

    task automatic drive(input logic [4:0] r, input logic rdy, input logic sel, input logic [1:0] tr,
                         input logic [2:0] bu, input logic lk);
        req_port = r; HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
        @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_reset();
        #2 HRESETn = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("async_rst%0d_hold", j), int'(hold_o[j]), 0);
            chk($sformatf("async_rst%0d_none", j), int'(none_o[j]), 1);
            chk($sformatf("async_rst%0d_port", j), int'(port_o[j]), 0);
        end
        req_port = '0; HSELM = 1'b0; HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0; HREADYM = 1'b1;
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    initial begin
        automatic int rr_exp [8] = '{0, 1, 3, 4, 0, 1, 3, 4};
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_none", int'(none_o[0]), 1);
        chk("reset_port", int'(port_o[0]), 0);
        chk("reset_hold", int'(hold_o[0]), 0);
        HRESETn = 1'b1;
        drive(5'b00000, 1, 0, 2'b00, 3'b000, 0);
        chk("idle_none", int'(none_o[0]), 1);
        drive(5'b00010, 1, 0, 2'b00, 3'b000, 0);
        chk("req1_port", int'(port_o[0]), 1);
        chk("req1_none", int'(none_o[0]), 0);
        chk("req1_masked_none", int'(none_o[1]), 1);
        drive(5'b11010, 1, 0, 2'b00, 3'b000, 0);
        chk("fixed_port", int'(port_o[0]), 1);
        chk("fixed_mask_port", int'(port_o[1]), 3);
        drive(5'b00100, 1, 0, 2'b00, 3'b000, 0);
        chk("masked2_none", int'(none_o[0]), 1);
        pulse_reset();
        for (int n = 0; n < 8; n++) begin
            drive(5'b11011, 1, 0, 2'b00, 3'b000, 0);
            chk($sformatf("rr_grant%0d", n), int'(port_o[2]), rr_exp[n]);
            chk($sformatf("fixed_grant%0d", n), int'(port_o[0]), 0);
        end
        for (int run = 0; run < 2; run++) begin
            drive(5'b01000, 1, 1, 2'b00, 3'b000, 0);
            chk("burst_start_port", int'(port_o[0]), 3);
            drive(5'b01000, 1, 1, 2'b10, 3'b101, 0);
            chk("incr8_hold", int'(hold_o[0]), 1);
            for (int b = 0; b < 3; b++) begin
                drive(5'b01001, 1, 1, 2'b11, 3'b101, 0);
                chk("incr8_seq_port", int'(port_o[0]), 3);
            end
            if (run == 0) begin
                drive(5'b01001, 1, 1, 2'b01, 3'b101, 0);
                chk("busy_hold", int'(hold_o[0]), 1);
                for (int b = 0; b < 4; b++) begin
                    drive(5'b01001, 1, 1, 2'b11, 3'b101, 0);
                    chk("incr8_tail_port", int'(port_o[0]), 3);
                end
                chk("incr8_done_hold", int'(hold_o[0]), 0);
            end else begin
                drive(5'b00001, 1, 1, 2'b00, 3'b101, 0);
                chk("early_idle_hold", int'(hold_o[0]), 0);
                chk("early_idle_port", int'(port_o[0]), 3);
            end
            drive(5'b00001, 1, 1, 2'b00, 3'b000, 0);
            chk("after_burst_port", int'(port_o[0]), 0);
        end
        drive(5'b10000, 1, 1, 2'b00, 3'b000, 0);
        chk("lock_setup_port", int'(port_o[0]), 4);
        drive(5'b00001, 1, 1, 2'b10, 3'b000, 1);
        drive(5'b00001, 1, 1, 2'b10, 3'b000, 1);
        chk("lock_port", int'(port_o[0]), 4);
        drive(5'b00010, 0, 1, 2'b00, 3'b000, 0);
        drive(5'b01000, 0, 0, 2'b00, 3'b000, 0);
        drive(5'b00001, 0, 0, 2'b00, 3'b000, 0);
        chk("stall_port", int'(port_o[0]), 4);
        chk("stall_none", int'(none_o[0]), 0);
        drive(5'b00001, 1, 0, 2'b00, 3'b000, 0);
        chk("unlock_port", int'(port_o[0]), 0);
        drive(5'b01000, 1, 1, 2'b00, 3'b000, 0);
        drive(5'b01000, 1, 1, 2'b10, 3'b111, 0);
        drive(5'b01001, 1, 1, 2'b11, 3'b111, 0);
        drive(5'b01001, 1, 1, 2'b11, 3'b111, 0);
        chk("incr16_hold", int'(hold_o[0]), 1);
        chk("incr16_port", int'(port_o[0]), 3);
        pulse_reset();
        drive(5'b00000, 1, 0, 2'b00, 3'b000, 0);
        chk("post_reset_none", int'(none_o[0]), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
